phase_bus_sequencer: RTL and testbench
======================================

Name: phase_bus_sequencer

Overview:
- Parametrised phase-bus transaction engine; successor to the fixed four-card write4/read4 sequencers.
- Runs WRITE, READ or ADC transactions over NUM_BOARDS cards, in board order 0..NUM_BOARDS-1.
- Honours a per-board enable mask and uses parametrised setup/strobe/hold timing.
- Sits between the command decoder (start/op/params) and the phase-bus pins; results go back to the UART response builder.

Parameters:
NUM_BOARDS, 4, number of cards on the phase bus (1..8)
DATA_W, 8, phase-bus data width
ADDR_W, 3, port address width
SETUP_CYCLES, 21, cycles address/data held before strobe (>=1)
STROBE_CYCLES, 2, cycles rd_n/wr_n held low (>=1)
HOLD_CYCLES, 21, cycles after strobe release before next access (>=1)
PORT_MUX, 3, analog mux port address
PORT_ADC_HIGH, 4, ADC high-byte port
PORT_ADC_LOW, 5, ADC low-byte port

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  2  0=WRITE, 1=READ, 2=ADC, 3=reserved
port_addr  in  ADDR_W  port for WRITE/READ
board_mask  in  NUM_BOARDS  bit b=1 enables card b
wr_data  in  NUM_BOARDS*DATA_W  slot b = write byte for card b
mux_sel  in  DATA_W  ADC mux channel
busy  out  1  high from accepted start through DONE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on reserved op or start while busy
rd_data  out  NUM_BOARDS*2*DATA_W  slot b = {hi,lo}; READ fills lo, zeroes hi
board_sel  out  NUM_BOARDS  one-hot card select (broadcast mask for ADC mux phase)
addr_out  out  ADDR_W  port address pins
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
data_out  out  DATA_W  bus output data
data_in  in  DATA_W  bus input data
data_dir  out  1  1=output, 0=input

Behaviour:
- Reset (async, any time, including mid-transaction):
  - State IDLE; rd_n=wr_n=1; data_dir=0.
  - board_sel=0, addr_out=0, data_out=0, rd_data=0.
  - busy=done=err=0; timer cleared.
- States: IDLE, SETUP, STROBE, HOLD, NEXT, DONE.
- ADC adds phase register: MUX_WR -> CONV_WR -> RD_HI -> RD_LO (per board).
- Start accepted in IDLE at cycle T:
  - op, port_addr, board_mask, wr_data and mux_sel are latched.
  - busy rises at T+1.
  - op=3: no bus activity; err pulses at T+1; stays IDLE.
- Timing per access:
  - SETUP lasts SETUP_CYCLES cycles: board_sel/addr_out/data_out/data_dir driven, strobes high.
  - STROBE lasts STROBE_CYCLES cycles: strobe low.
  - HOLD lasts HOLD_CYCLES cycles: strobe high, address/data unchanged.
  - NEXT lasts 1 cycle.
  - Access slot length S = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + 1.
- WRITE: per enabled board, board_sel=1<<b, data_dir=1, data_out=wr_data slot b, wr_n strobed.
- READ:
  - data_dir=0, rd_n strobed.
  - data_in is captured on the final STROBE-cycle edge into rd_data[b] lo; hi is cleared.
  - Disabled boards' slots keep their previous value.
- ADC:
  - MUX_WR: board_sel=board_mask, addr_out=PORT_MUX, data_out=mux_sel, data_dir=1, wr_n strobe.
  - CONV_WR: same address, second wr_n strobe.
  - Then data_dir=0; per enabled board, RD_HI at PORT_ADC_HIGH, then RD_LO at PORT_ADC_LOW, captured into hi/lo.
- Disabled boards take zero cycles; NEXT advances directly to the next enabled board.
- Empty mask: no bus activity (ADC also skips mux/convert); DONE at T+2.
- DONE lasts 1 cycle:
  - done=1, busy drops the following cycle.
  - Bus returns to idle values; rd_data is stable from the DONE cycle until the next start.
- start while busy: ignored, err pulses the next cycle, transaction unaffected.
- Total latency, start cycle T to done:
  - WRITE/READ: T+1+k*S, where k = popcount(board_mask).
  - ADC: T+1+(2+2k)*S.
- rd_n and wr_n are never low simultaneously; any address/data change happens only with both strobes high.

Decomposition:
- Package phase_bus_pkg holds:
  - op enum (PB_OP_WRITE/READ/ADC).
  - dir enum (DIR_INPUT=0, DIR_OUTPUT=1).
  - strobe enum (ENABLE=0, DISABLE=1).
  - state and ADC-phase enums.
  - Default port constants.
- Sub-module pb_wait_timer:
  - Loadable down-counter with load, value and expired outputs.
  - Width $clog2 of the maximum of the three timing parameters, plus 1.

Test Plan:
- SETUP=2, STROBE=1, HOLD=2 (S=6) are used throughout.
- WRITE, mask 4'b1111, wr_data=0xD4C3B2A1, port 2:
  - Exactly four wr_n pulses with board_sel 1,2,4,8 and data A1,B2,C3,D4.
  - done at T+25.
- READ, mask 4'b0101, bench drives data_in 0x5A for card 0 and 0x3C for card 2:
  - rd_data slot0=0x005A, slot2=0x003C, slots 1/3 unchanged.
  - Only board_sel 1 and 4 seen; done at T+13.
- ADC, mask 4'b1111, mux_sel=0x07:
  - Two broadcast wr_n pulses to port 3 with data 0x07, then eight rd_n pulses alternating ports 4/5.
  - Each slot = {hi,lo} of driven bytes; done at T+61.
- Empty mask or op=3:
  - Empty mask: no strobe ever low; done at T+2.
  - op=3: err at T+1 and no done.
- start pulsed mid-WRITE: err pulse one cycle later; original write sequence and done timing unchanged.
- reset asserted during a STROBE cycle of READ:
  - rd_n=1, data_dir=0, busy=0 and rd_data=0 immediately (asynchronously).
  - A new start after release runs normally.

Source files
------------

// File: rtl/phase_bus_pkg.sv
// Shared types and constants for the phase-bus transaction engine.
// Contents:
//   pb_op_e      transaction opcode as driven by the command decoder
//   pb_dir_e     data pin direction (input / output)
//   pb_strobe_e  active-low strobe level (ENABLE drives the pin low)
//   pb_state_e   per-access sequencer states
//   pb_phase_e   sub-phase of an ADC transaction
//   PB_DEF_*     default port addresses of the analog front end
//   pb_next_board  lowest enabled card index at or above a start index
package phase_bus_pkg;

  typedef enum logic [1:0] {
    PB_OP_WRITE = 2'd0,
    PB_OP_READ  = 2'd1,
    PB_OP_ADC   = 2'd2,
    PB_OP_RSVD  = 2'd3
  } pb_op_e;

  typedef enum logic {
    DIR_INPUT  = 1'b0,
    DIR_OUTPUT = 1'b1
  } pb_dir_e;

  typedef enum logic {
    ENABLE  = 1'b0,
    DISABLE = 1'b1
  } pb_strobe_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } pb_state_e;

  typedef enum logic [1:0] {
    PH_MUX_WR  = 2'd0,
    PH_CONV_WR = 2'd1,
    PH_RD_HI   = 2'd2,
    PH_RD_LO   = 2'd3
  } pb_phase_e;

  localparam int PB_DEF_PORT_MUX      = 3;
  localparam int PB_DEF_PORT_ADC_HIGH = 4;
  localparam int PB_DEF_PORT_ADC_LOW  = 5;

  // Returns {found, index}. The mask is zero-extended to eight cards so the
  // same search serves any board count; scanning downwards leaves the lowest
  // qualifying index in the result.
  function automatic logic [3:0] pb_next_board(input logic [7:0] mask,
                                               input logic [3:0] from);
    logic [3:0] result;
    result = 4'b0000;
    for (int b = 7; b >= 0; b--) begin
      if (mask[b] && (b >= int'(from))) begin
        result = {1'b1, 3'(b)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pb_wait_timer.sv
// Loadable down-counter that times each bus phase.
// Ports:
//   clock      system clock
//   reset      asynchronous active-high reset, clears the count
//   i_load     load i_value on the next edge
//   i_value    cycles remaining minus one for the phase being entered
//   o_expired  high while the count is zero (last cycle of the phase)
module pb_wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Count down to zero and park there; a load always wins over counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/phase_bus_sequencer.sv
// Phase-bus transaction engine: runs WRITE, READ or ADC transactions over
// NUM_BOARDS cards in ascending board order, skipping cards whose mask bit
// is clear, with setup/strobe/hold timing set by parameters.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start, op             one-cycle request and opcode (accepted in IDLE)
//   port_addr, board_mask, wr_data, mux_sel   transaction parameters
//   busy, done, err       status towards the command decoder
//   rd_data               per-card {hi,lo} results
//   board_sel, addr_out, rd_n, wr_n, data_out, data_in, data_dir  bus pins
module phase_bus_sequencer
  import phase_bus_pkg::*;
#(
  parameter int NUM_BOARDS    = 4,
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 3,
  parameter int SETUP_CYCLES  = 21,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 21,
  parameter int PORT_MUX      = PB_DEF_PORT_MUX,
  parameter int PORT_ADC_HIGH = PB_DEF_PORT_ADC_HIGH,
  parameter int PORT_ADC_LOW  = PB_DEF_PORT_ADC_LOW
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   op,
  input  logic [ADDR_W-1:0]            port_addr,
  input  logic [NUM_BOARDS-1:0]        board_mask,
  input  logic [NUM_BOARDS*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]            mux_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [NUM_BOARDS*2*DATA_W-1:0] rd_data,
  output logic [NUM_BOARDS-1:0]        board_sel,
  output logic [ADDR_W-1:0]            addr_out,
  output logic                         rd_n,
  output logic                         wr_n,
  output logic [DATA_W-1:0]            data_out,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         data_dir
);

  localparam int MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC) + 1;
  localparam int SLOT_W  = 2 * DATA_W;

  localparam logic [TIMER_W-1:0] LOAD_SETUP  = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOAD_STROBE = TIMER_W'(STROBE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOAD_HOLD   = TIMER_W'(HOLD_CYCLES - 1);

  pb_state_e                   r_state;
  pb_phase_e                   r_phase;
  pb_op_e                      r_op;
  logic [ADDR_W-1:0]           r_port;
  logic [NUM_BOARDS-1:0]       r_mask;
  logic [NUM_BOARDS*DATA_W-1:0] r_wrData;
  logic [DATA_W-1:0]           r_muxSel;
  logic [2:0]                  r_board;
  logic [NUM_BOARDS*SLOT_W-1:0] r_rdData;
  logic                        r_err;

  pb_state_e             w_stateNext;
  pb_phase_e             w_phaseNext;
  logic [2:0]            w_boardNext;
  logic                  w_timerLoad;
  logic [TIMER_W-1:0]    w_timerValue;
  logic                  w_timerExpired;
  pb_op_e                w_opIn;
  logic [3:0]            w_searchStart;
  logic [3:0]            w_searchFirst;
  logic [3:0]            w_searchAfter;
  logic [NUM_BOARDS-1:0] w_boardOneHot;
  logic [NUM_BOARDS-1:0] w_sel;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_dout;
  pb_dir_e               w_dir;
  pb_strobe_e            w_rdStrobe;
  pb_strobe_e            w_wrStrobe;
  logic                  w_isRead;
  logic                  w_capture;

  pb_wait_timer #(.WIDTH(TIMER_W)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_timerLoad),
    .i_value   (w_timerValue),
    .o_expired (w_timerExpired)
  );

  assign w_opIn        = pb_op_e'(op);
  assign w_searchStart = pb_next_board(8'(board_mask), 4'd0);
  assign w_searchFirst = pb_next_board(8'(r_mask), 4'd0);
  assign w_searchAfter = pb_next_board(8'(r_mask), {1'b0, r_board} + 4'd1);
  assign w_boardOneHot = NUM_BOARDS'(1) << r_board;

  // State, ADC phase, current card, latched request and the read-back buffer.
  // The request is latched on acceptance so decoder inputs may change freely
  // while the transaction runs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_MUX_WR;
      r_op     <= PB_OP_WRITE;
      r_port   <= '0;
      r_mask   <= '0;
      r_wrData <= '0;
      r_muxSel <= '0;
      r_board  <= '0;
      r_rdData <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_phase <= w_phaseNext;
      r_board <= w_boardNext;
      r_err   <= start && ((r_state != ST_IDLE) || (w_opIn == PB_OP_RSVD));
      if ((r_state == ST_IDLE) && start) begin
        r_op     <= w_opIn;
        r_port   <= port_addr;
        r_mask   <= board_mask;
        r_wrData <= wr_data;
        r_muxSel <= mux_sel;
      end
      if (w_capture) begin
        if (r_op == PB_OP_READ) begin
          r_rdData[int'(r_board)*SLOT_W +: SLOT_W] <= {{DATA_W{1'b0}}, data_in};
        end else if (r_phase == PH_RD_HI) begin
          r_rdData[int'(r_board)*SLOT_W + DATA_W +: DATA_W] <= data_in;
        end else begin
          r_rdData[int'(r_board)*SLOT_W +: DATA_W] <= data_in;
        end
      end
    end
  end

  // Next-state logic. Every access is SETUP -> STROBE -> HOLD -> NEXT; NEXT
  // picks the following access (next ADC phase or next enabled card) so
  // disabled cards cost no cycles. An empty mask goes straight to NEXT, whose
  // search then finds nothing and finishes.
  always_comb begin
    w_stateNext  = r_state;
    w_phaseNext  = r_phase;
    w_boardNext  = r_board;
    w_timerLoad  = 1'b0;
    w_timerValue = '0;
    case (r_state)
      ST_IDLE: begin
        if (start && (w_opIn == PB_OP_ADC)) begin
          if (|board_mask) begin
            w_phaseNext  = PH_MUX_WR;
            w_stateNext  = ST_SETUP;
            w_timerLoad  = 1'b1;
            w_timerValue = LOAD_SETUP;
          end else begin
            w_phaseNext = PH_RD_LO;
            w_stateNext = ST_NEXT;
          end
        end else if (start && (w_opIn != PB_OP_RSVD)) begin
          if (w_searchStart[3]) begin
            w_boardNext  = w_searchStart[2:0];
            w_stateNext  = ST_SETUP;
            w_timerLoad  = 1'b1;
            w_timerValue = LOAD_SETUP;
          end else begin
            w_stateNext = ST_NEXT;
          end
        end
      end
      ST_SETUP: begin
        if (w_timerExpired) begin
          w_stateNext  = ST_STROBE;
          w_timerLoad  = 1'b1;
          w_timerValue = LOAD_STROBE;
        end
      end
      ST_STROBE: begin
        if (w_timerExpired) begin
          w_stateNext  = ST_HOLD;
          w_timerLoad  = 1'b1;
          w_timerValue = LOAD_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_timerExpired) begin
          w_stateNext = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_stateNext  = ST_DONE;
        w_timerValue = LOAD_SETUP;
        if (r_op == PB_OP_ADC) begin
          case (r_phase)
            PH_MUX_WR: begin
              w_phaseNext = PH_CONV_WR;
              w_stateNext = ST_SETUP;
              w_timerLoad = 1'b1;
            end
            PH_CONV_WR: begin
              if (w_searchFirst[3]) begin
                w_boardNext = w_searchFirst[2:0];
                w_phaseNext = PH_RD_HI;
                w_stateNext = ST_SETUP;
                w_timerLoad = 1'b1;
              end
            end
            PH_RD_HI: begin
              w_phaseNext = PH_RD_LO;
              w_stateNext = ST_SETUP;
              w_timerLoad = 1'b1;
            end
            default: begin
              if (w_searchAfter[3]) begin
                w_boardNext = w_searchAfter[2:0];
                w_phaseNext = PH_RD_HI;
                w_stateNext = ST_SETUP;
                w_timerLoad = 1'b1;
              end
            end
          endcase
        end else if (w_searchAfter[3]) begin
          w_boardNext = w_searchAfter[2:0];
          w_stateNext = ST_SETUP;
          w_timerLoad = 1'b1;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Bus pin values. Address, data and direction are held through SETUP,
  // STROBE and HOLD and fall back to idle values otherwise, so they only
  // change while both strobes are high. The ADC mux/convert writes
  // broadcast to every enabled card at once.
  always_comb begin
    w_sel      = '0;
    w_addr     = '0;
    w_dout     = '0;
    w_dir      = DIR_INPUT;
    w_rdStrobe = DISABLE;
    w_wrStrobe = DISABLE;
    w_isRead   = 1'b0;
    if ((r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD)) begin
      case (r_op)
        PB_OP_WRITE: begin
          w_sel  = w_boardOneHot;
          w_addr = r_port;
          w_dout = r_wrData[int'(r_board)*DATA_W +: DATA_W];
          w_dir  = DIR_OUTPUT;
        end
        PB_OP_READ: begin
          w_sel    = w_boardOneHot;
          w_addr   = r_port;
          w_isRead = 1'b1;
        end
        PB_OP_ADC: begin
          case (r_phase)
            PH_MUX_WR, PH_CONV_WR: begin
              w_sel  = r_mask;
              w_addr = ADDR_W'(PORT_MUX);
              w_dout = r_muxSel;
              w_dir  = DIR_OUTPUT;
            end
            PH_RD_HI: begin
              w_sel    = w_boardOneHot;
              w_addr   = ADDR_W'(PORT_ADC_HIGH);
              w_isRead = 1'b1;
            end
            default: begin
              w_sel    = w_boardOneHot;
              w_addr   = ADDR_W'(PORT_ADC_LOW);
              w_isRead = 1'b1;
            end
          endcase
        end
        default: begin
          w_sel = '0;
        end
      endcase
      if (r_state == ST_STROBE) begin
        if (w_isRead) begin
          w_rdStrobe = ENABLE;
        end else begin
          w_wrStrobe = ENABLE;
        end
      end
    end
  end

  // Read data is sampled on the edge that ends the last strobe cycle.
  assign w_capture = (r_state == ST_STROBE) && w_timerExpired && w_isRead;

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign rd_data   = r_rdData;
  assign board_sel = w_sel;
  assign addr_out  = w_addr;
  assign data_out  = w_dout;
  assign data_dir  = w_dir;
  assign rd_n      = w_rdStrobe;
  assign wr_n      = w_wrStrobe;

endmodule

// File: tb/tb_phase_bus_sequencer.sv
// Directed bench for phase_bus_sequencer with SETUP=2, STROBE=1, HOLD=2
// (six-cycle access slot) and four cards. A small card model answers reads;
// a negedge monitor logs every strobe falling edge and checks bus stability.
module tb_phase_bus_sequencer;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = 2'd0;
  logic [AW-1:0]   port_addr = '0;
  logic [NB-1:0]   board_mask = '0;
  logic [NB*DW-1:0] wr_data = '0;
  logic [DW-1:0]   mux_sel = '0;
  logic [DW-1:0]   data_in;
  logic            busy;
  logic            done;
  logic            err;
  logic [NB*2*DW-1:0] rd_data;
  logic [NB-1:0]   board_sel;
  logic [AW-1:0]   addr_out;
  logic            rd_n;
  logic            wr_n;
  logic [DW-1:0]   data_out;
  logic            data_dir;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cycleCnt   = 0;
  int violations = 0;
  int t;
  int c;

  logic [3:0] wrSel[$];
  logic [2:0] wrAddr[$];
  logic [7:0] wrData[$];
  logic       wrDir[$];
  logic [3:0] rdSel[$];
  logic [2:0] rdAddr[$];
  logic       rdDir[$];

  logic       prevWr = 1'b1;
  logic       prevRd = 1'b1;
  logic       prevValid = 1'b0;
  logic [3:0] prevSel = '0;
  logic [2:0] prevAddr = '0;
  logic [7:0] prevData = '0;

  logic [3:0] expSelW[4]  = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [7:0] expDataW[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] expDataM[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [3:0] expSelA[8]  = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
  logic [2:0] expAddrA[8] = '{3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5};

  phase_bus_sequencer #(
    .NUM_BOARDS    (NB),
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .SETUP_CYCLES  (2),
    .STROBE_CYCLES (1),
    .HOLD_CYCLES   (2),
    .PORT_MUX      (3),
    .PORT_ADC_HIGH (4),
    .PORT_ADC_LOW  (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .port_addr  (port_addr),
    .board_mask (board_mask),
    .wr_data    (wr_data),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_data    (rd_data),
    .board_sel  (board_sel),
    .addr_out   (addr_out),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .data_out   (data_out),
    .data_in    (data_in),
    .data_dir   (data_dir)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Card model: port 6 is a plain register, ports 4/5 the ADC result bytes.
  always_comb begin
    data_in = 8'h00;
    case (addr_out)
      3'd6: begin
        case (board_sel)
          4'b0001: data_in = 8'h5A;
          4'b0010: data_in = 8'hEE;
          4'b0100: data_in = 8'h3C;
          4'b1000: data_in = 8'hDD;
          default: data_in = 8'h00;
        endcase
      end
      3'd4: begin
        case (board_sel)
          4'b0001: data_in = 8'h81;
          4'b0010: data_in = 8'h82;
          4'b0100: data_in = 8'h83;
          4'b1000: data_in = 8'h84;
          default: data_in = 8'h00;
        endcase
      end
      3'd5: begin
        case (board_sel)
          4'b0001: data_in = 8'h41;
          4'b0010: data_in = 8'h42;
          4'b0100: data_in = 8'h43;
          4'b1000: data_in = 8'h44;
          default: data_in = 8'h00;
        endcase
      end
      default: data_in = 8'h00;
    endcase
  end

  // Strobe logger and bus-stability watchdog.
  always @(negedge clock) begin
    if (reset) begin
      prevWr    <= 1'b1;
      prevRd    <= 1'b1;
      prevValid <= 1'b0;
    end else begin
      if ((rd_n === 1'b0 && wr_n === 1'b0) ||
          (prevValid && (prevWr === 1'b0 || prevRd === 1'b0 || wr_n === 1'b0 || rd_n === 1'b0) &&
           (board_sel !== prevSel || addr_out !== prevAddr || data_out !== prevData))) begin
        violations <= violations + 1;
      end
      if (prevWr === 1'b1 && wr_n === 1'b0) begin
        wrSel.push_back(board_sel);
        wrAddr.push_back(addr_out);
        wrData.push_back(data_out);
        wrDir.push_back(data_dir);
      end
      if (prevRd === 1'b1 && rd_n === 1'b0) begin
        rdSel.push_back(board_sel);
        rdAddr.push_back(addr_out);
        rdDir.push_back(data_dir);
      end
      prevWr    <= wr_n;
      prevRd    <= rd_n;
      prevSel   <= board_sel;
      prevAddr  <= addr_out;
      prevData  <= data_out;
      prevValid <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Presents a request during one cycle T (returned in tOut); returns at T+1.
  task automatic applyStimulus(input logic [1:0] o, input logic [2:0] p, input logic [3:0] m,
                               input logic [31:0] wd, input logic [7:0] mx, output int tOut);
    @(negedge clock);
    tOut       = cycleCnt;
    op         = o;
    port_addr  = p;
    board_mask = m;
    wr_data    = wd;
    mux_sel    = mx;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        cyc = cycleCnt;
        break;
      end
    end
  endtask

  task automatic clearLogs();
    wrSel.delete();
    wrAddr.delete();
    wrData.delete();
    wrDir.delete();
    rdSel.delete();
    rdAddr.delete();
    rdDir.delete();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    checkOutput("rst_strobes", {61'd0, rd_n, wr_n, data_dir}, 64'b110);
    checkOutput("rst_flags", {61'd0, busy, done, err}, 64'd0);
    checkOutput("rst_bus", {53'd0, board_sel, addr_out, data_out}, 64'd0);
    checkOutput("rst_rddata", rd_data, 64'd0);
    #2 reset = 1'b0;
    @(negedge clock);
    clearLogs();

    $display("[TB] WRITE mask 1111 port 2");
    applyStimulus(2'd0, 3'd2, 4'b1111, 32'hD4C3B2A1, 8'h00, t);
    checkOutput("wr_busy", {63'd0, busy}, 64'd1);
    waitDone(100, c);
    checkOutput("wr_done_cycle", c, t + 25);
    @(negedge clock);
    checkOutput("wr_after_done", {62'd0, busy, done}, 64'd0);
    checkOutput("wr_count", wrSel.size(), 4);
    checkOutput("wr_rdcount", rdSel.size(), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr_sel%0d", i), wrSel[i], expSelW[i]);
      checkOutput($sformatf("wr_data%0d", i), wrData[i], expDataW[i]);
      checkOutput($sformatf("wr_addr%0d", i), wrAddr[i], 3'd2);
      checkOutput($sformatf("wr_dir%0d", i), wrDir[i], 1'b1);
    end

    $display("[TB] ADC mask 1111 mux 07");
    clearLogs();
    applyStimulus(2'd2, 3'd0, 4'b1111, 32'h0, 8'h07, t);
    waitDone(200, c);
    checkOutput("adc_done_cycle", c, t + 61);
    checkOutput("adc_wrcount", wrSel.size(), 2);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("adc_wsel%0d", i), wrSel[i], 4'hF);
      checkOutput($sformatf("adc_waddr%0d", i), wrAddr[i], 3'd3);
      checkOutput($sformatf("adc_wdata%0d", i), wrData[i], 8'h07);
    end
    checkOutput("adc_rdcount", rdSel.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("adc_rsel%0d", i), rdSel[i], expSelA[i]);
      checkOutput($sformatf("adc_raddr%0d", i), rdAddr[i], expAddrA[i]);
      checkOutput($sformatf("adc_rdir%0d", i), rdDir[i], 1'b0);
    end
    checkOutput("adc_rddata", rd_data, 64'h8444_8343_8242_8141);

    $display("[TB] READ mask 0101 port 6");
    clearLogs();
    applyStimulus(2'd1, 3'd6, 4'b0101, 32'h0, 8'h00, t);
    waitDone(100, c);
    checkOutput("rd_done_cycle", c, t + 13);
    checkOutput("rd_count", rdSel.size(), 2);
    checkOutput("rd_sel0", rdSel[0], 4'h1);
    checkOutput("rd_sel1", rdSel[1], 4'h4);
    checkOutput("rd_wrcount", wrSel.size(), 0);
    checkOutput("rd_rddata", rd_data, 64'h8444_003C_8242_005A);

    $display("[TB] empty mask WRITE and ADC");
    clearLogs();
    applyStimulus(2'd0, 3'd2, 4'b0000, 32'h12345678, 8'h00, t);
    waitDone(20, c);
    checkOutput("empty_wr_done", c, t + 2);
    applyStimulus(2'd2, 3'd0, 4'b0000, 32'h0, 8'h07, t);
    waitDone(20, c);
    checkOutput("empty_adc_done", c, t + 2);
    checkOutput("empty_strobes", wrSel.size() + rdSel.size(), 0);

    $display("[TB] reserved op");
    applyStimulus(2'd3, 3'd2, 4'b1111, 32'h0, 8'h00, t);
    checkOutput("rsvd_err_busy", {62'd0, err, busy}, 64'b10);
    waitDone(20, c);
    checkOutput("rsvd_no_done", c, -1);
    checkOutput("rsvd_err_clear", {63'd0, err}, 64'd0);
    checkOutput("rsvd_strobes", wrSel.size() + rdSel.size(), 0);

    $display("[TB] start during WRITE");
    clearLogs();
    applyStimulus(2'd0, 3'd2, 4'b1111, 32'h44332211, 8'h00, t);
    repeat (3) @(negedge clock);
    op         = 2'd1;
    board_mask = 4'b0001;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("busy_start_err", {63'd0, err}, 64'd1);
    @(negedge clock);
    checkOutput("busy_err_pulse", {63'd0, err}, 64'd0);
    waitDone(100, c);
    checkOutput("busy_done_cycle", c, t + 25);
    checkOutput("busy_wrcount", wrSel.size(), 4);
    checkOutput("busy_rdcount", rdSel.size(), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("busy_data%0d", i), wrData[i], expDataM[i]);
      checkOutput($sformatf("busy_sel%0d", i), wrSel[i], expSelW[i]);
    end
    checkOutput("protocol", violations, 0);

    $display("[TB] reset during READ strobe");
    clearLogs();
    applyStimulus(2'd1, 3'd6, 4'b0001, 32'h0, 8'h00, t);
    repeat (2) @(negedge clock);
    checkOutput("rstmid_strobe_low", {63'd0, rd_n}, 64'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstmid_pins", {61'd0, rd_n, data_dir, busy}, 64'b100);
    checkOutput("rstmid_rddata", rd_data, 64'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    applyStimulus(2'd1, 3'd6, 4'b0101, 32'h0, 8'h00, t);
    waitDone(100, c);
    checkOutput("rstmid_rerun_done", c, t + 13);
    checkOutput("rstmid_rerun_data", rd_data, 64'h0000_003C_0000_005A);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
